// File: rtl/spdif_lock_ctrl.sv
// spdif_lock_ctrl: measures the S/PDIF unit interval from edge lengths, programs decoder
// thresholds, confirms subframe sync spacing and supervises lock / loss of signal.
module spdif_lock_ctrl #(
  parameter int LEN_W       = 8,
  parameter int MEAS_EDGES  = 64,
  parameter int SYNC_NEEDED = 4,
  parameter int ERR_LIMIT   = 8,
  parameter int MIN_UI      = 4,
  parameter int TIMEOUT     = 1023,
  parameter int T1_RST      = 20,
  parameter int T2_RST      = 38,
  parameter int T3_RST      = 42
) (
  input  logic             clk_in,
  input  logic             resetb,
  input  logic             edge_valid,
  input  logic [LEN_W-1:0] edge_len,
  output logic [LEN_W-1:0] thr_t1,
  output logic [LEN_W-1:0] thr_t2,
  output logic [LEN_W-1:0] thr_t3,
  output logic             dec_run,
  output logic             dec_restart,
  output logic             audio_locked,
  output logic             sync_pulse,
  output logic [1:0]       lock_state
);
  localparam int CW = $clog2(MEAS_EDGES + 1);
  localparam int GW = $clog2(SYNC_NEEDED + 1);
  localparam int EW = $clog2(ERR_LIMIT + 2) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int XW = LEN_W + 2;

  typedef enum logic [1:0] {IDLE, MEASURE, CONFIRM, LOCKED} state_t;

  state_t           state, state_n;
  logic [LEN_W-1:0] min_len, min_n, min_upd, t4, t4_n, t1_n, t2_n, t3_n;
  logic [CW-1:0]    edge_cnt, cnt_n;
  logic [6:0]       acc, acc_n, acc_new, acc_upd;
  logic [GW-1:0]    good_cnt, good_n, good_inc;
  logic [EW-1:0]    err, err_n, err_upd, err_up, err_dec;
  logic [EW:0]      err_add;
  logic [TW-1:0]    idle_cnt, idle_n;
  logic             anchored, anch_n, restart_n, pulse_n, run_n, lock_n;
  logic [XW-1:0]    uw, d1, d2, d3, d4;
  logic [1:0]       ui;
  logic             is_short, is_mid, is_long, invalid, preamble, good_sync, bad_sync, anchor, timeout;

  function automatic logic [LEN_W-1:0] sat(input logic [XW-1:0] v);
    return |v[XW-1:LEN_W] ? '1 : v[LEN_W-1:0];
  endfunction

  assign min_upd = edge_len < min_len ? edge_len : min_len;
  assign uw = XW'(min_upd);
  assign d1 = uw + (uw >> 1);
  assign d2 = (uw << 1) + (uw >> 1);
  assign d3 = (uw << 1) + uw - (uw >> 2);
  assign d4 = (uw << 1) + uw + (uw >> 1);

  // Short/mid take priority so a degenerate threshold set never double-classifies.
  assign is_short  = edge_len <= thr_t1;
  assign is_mid    = !is_short && edge_len <= thr_t2;
  assign is_long   = !is_short && !is_mid && edge_len > thr_t3 && edge_len <= t4;
  assign invalid   = !(is_short || is_mid || is_long);
  assign ui        = is_short ? 2'd1 : is_mid ? 2'd2 : is_long ? 2'd3 : 2'd0;
  assign acc_new   = acc + {5'd0, ui};
  assign preamble  = acc_new < 7'd8;
  assign good_sync = is_long && acc_new == 7'd64;
  assign bad_sync  = is_long ? !preamble && !good_sync : !invalid && acc_new > 7'd72;
  assign anchor    = is_long && !preamble && !anchored && good_cnt == '0;
  assign acc_upd   = invalid ? acc : (is_long && preamble) || (!is_long && !bad_sync) ? acc_new : 7'd0;
  assign good_inc  = good_cnt + GW'(1);

  assign err_add = {1'b0, err} + (EW+1)'(2);
  assign err_up  = err_add[EW] ? '1 : err_add[EW-1:0];
  assign err_dec = err == '0 ? '0 : err - EW'(1);
  assign err_upd = (invalid || bad_sync) ? err_up : good_sync ? err_dec : err;

  assign timeout = !edge_valid && idle_cnt == TW'(TIMEOUT - 1);
  assign lock_state = state;

  always_comb begin
    state_n   = state;
    min_n     = min_len;
    cnt_n     = edge_cnt;
    acc_n     = acc;
    good_n    = good_cnt;
    err_n     = err;
    anch_n    = anchored;
    t1_n      = thr_t1;
    t2_n      = thr_t2;
    t3_n      = thr_t3;
    t4_n      = t4;
    restart_n = 1'b0;
    pulse_n   = 1'b0;
    idle_n    = (edge_valid || timeout) ? '0 : idle_cnt + TW'(1);
    if (timeout)
      state_n = IDLE;
    else if (edge_valid)
      case (state)
        IDLE: begin
          state_n = MEASURE;
          cnt_n   = '0;
          min_n   = '1;
        end
        MEASURE: begin
          min_n = min_upd;
          cnt_n = edge_cnt + CW'(1);
          if (edge_cnt == CW'(MEAS_EDGES - 1)) begin
            cnt_n = '0;
            min_n = '1;
            if (min_upd >= LEN_W'(MIN_UI)) begin
              state_n   = CONFIRM;
              t1_n      = sat(d1);
              t2_n      = sat(d2);
              t3_n      = sat(d3);
              t4_n      = sat(d4);
              acc_n     = '0;
              good_n    = '0;
              anch_n    = 1'b0;
              restart_n = 1'b1;
            end
          end
        end
        CONFIRM: begin
          acc_n = acc_upd;
          if (anchor) begin
            acc_n  = '0;
            anch_n = 1'b1;
          end else if (invalid || bad_sync) begin
            state_n = MEASURE;
            cnt_n   = '0;
            min_n   = '1;
          end else if (good_sync) begin
            good_n = good_inc;
            if (good_inc == GW'(SYNC_NEEDED)) begin
              state_n = LOCKED;
              err_n   = '0;
            end
          end
        end
        default: begin
          acc_n   = acc_upd;
          err_n   = err_upd;
          pulse_n = good_sync;
          if (err_upd >= EW'(ERR_LIMIT)) begin
            state_n = MEASURE;
            cnt_n   = '0;
            min_n   = '1;
          end
        end
      endcase
    run_n  = state_n == CONFIRM || state_n == LOCKED;
    lock_n = state_n == LOCKED;
  end

  always_ff @(posedge clk_in or negedge resetb)
    if (!resetb) begin
      state        <= IDLE;
      min_len      <= '1;
      edge_cnt     <= '0;
      acc          <= '0;
      good_cnt     <= '0;
      err          <= '0;
      anchored     <= 1'b0;
      idle_cnt     <= '0;
      thr_t1       <= LEN_W'(T1_RST);
      thr_t2       <= LEN_W'(T2_RST);
      thr_t3       <= LEN_W'(T3_RST);
      t4           <= '1;
      dec_run      <= 1'b0;
      dec_restart  <= 1'b0;
      audio_locked <= 1'b0;
      sync_pulse   <= 1'b0;
    end else begin
      state        <= state_n;
      min_len      <= min_n;
      edge_cnt     <= cnt_n;
      acc          <= acc_n;
      good_cnt     <= good_n;
      err          <= err_n;
      anchored     <= anch_n;
      idle_cnt     <= idle_n;
      thr_t1       <= t1_n;
      thr_t2       <= t2_n;
      thr_t3       <= t3_n;
      t4           <= t4_n;
      dec_run      <= run_n;
      dec_restart  <= restart_n;
      audio_locked <= lock_n;
      sync_pulse   <= pulse_n;
    end
endmodule

// File: doc/spdif_lock_ctrl.md
# spdif_lock_ctrl

Acquisition and lock controller for the S/PDIF receive path. It consumes the edge-interval stream produced by the biphase edge detector and estimates the unit interval (UI) from the shortest observed interval. From that estimate it programs the decoder's pulse-classification thresholds, then confirms subframe sync spacing before asserting `audio_locked`. It sequences the decoder (run/restart) and drops lock on sustained line errors or loss of signal.

## Interface
- `LEN_W`, 8: edge-length width.
- `MEAS_EDGES`, 64: edges observed per UI measurement window.
- `SYNC_NEEDED`, 4: consecutive good syncs required to lock.
- `ERR_LIMIT`, 8: error score that forces loss of lock.
- `MIN_UI`, 4: smallest accepted UI estimate, in clocks.
- `TIMEOUT`, 1023: idle clocks with no edge before loss of signal.
- `T1_RST`/`T2_RST`/`T3_RST`, 20/38/42: threshold reset values.
- `clk_in` in 1: single clock.
- `resetb` in 1: asynchronous, active-low reset.
- `edge_valid` in 1: one-cycle pulse per detected rx edge.
- `edge_len` in LEN_W: clocks between previous edge and this one, minus 1.
- `thr_t1`, `thr_t2`, `thr_t3` out LEN_W: decoder thresholds.
- `dec_run` out 1: decoder enable.
- `dec_restart` out 1: one-cycle decoder re-search pulse.
- `audio_locked` out 1: lock indication.
- `sync_pulse` out 1: one-cycle pulse per good sync while locked.
- `lock_state` out 2: 0 IDLE, 1 MEASURE, 2 CONFIRM, 3 LOCKED.

## Operation
- Reset values: state IDLE; thresholds `T1_RST`/`T2_RST`/`T3_RST`; all other outputs 0; internal counters 0; `min_len` all-ones.
- UI estimate `u` = minimum `edge_len` over the window.
- Derived values, computed at LEN_W+2 bits and saturated to all-ones when stored:
  - T1 = u + (u>>1)
  - T2 = 2u + (u>>1)
  - T3 = 3u − (u>>2)
  - T4 (internal only) = 3u + (u>>1)
- Edge classification against the current stored thresholds:
  - `len` ≤ T1: short, 1 UI.
  - T1 < `len` ≤ T2: mid, 2 UI.
  - T3 < `len` ≤ T4: long, 3 UI.
  - Anything else: invalid.
- UI accumulator `acc` (7 bit) sums the class UI of every valid edge. On a long edge, `acc_new = acc + 3`:
  - `acc_new` < 8: preamble-internal. Keep accumulating.
  - `acc_new` == 64: good sync. `acc` ← 0.
  - Otherwise: bad sync. `acc` ← 0.
- If `acc_new` > 72 on a non-long edge: bad sync, `acc` ← 0.
- State machine:
  - IDLE: `dec_run` = 0. First `edge_valid` → MEASURE, which clears the edge count and `min_len`.
  - MEASURE: `dec_run` = 0. Each edge updates `min_len` and increments the count.
    - On edge number MEAS_EDGES, `min_len` includes that edge.
    - If `u` ≥ MIN_UI: register T1/T2/T3 into the outputs, clear `acc`, go to CONFIRM, and pulse `dec_restart`.
    - Else: restart MEASURE with the window cleared.
  - CONFIRM: `dec_run` = 1. Good sync increments `good_cnt`.
    - Reaching SYNC_NEEDED → LOCKED, with `err` ← 0.
    - Any invalid edge or bad sync → MEASURE.
    - Before the first good sync, the first long edge with `acc_new` ≥ 8 only anchors: `acc` ← 0, not counted as bad.
  - LOCKED: `dec_run` = 1, `audio_locked` = 1.
    - Invalid edge or bad sync: `err` += 2, saturating.
    - Good sync: `err` −= 1, floor 0, and `sync_pulse` asserted.
    - `err` ≥ ERR_LIMIT → MEASURE, with `audio_locked` cleared.
- Loss of signal: idle counter resets on every `edge_valid`. Reaching TIMEOUT in any state → IDLE.
  - Thresholds retain their last values.
  - `dec_run` = 0 and `audio_locked` = 0.
- Simultaneous events:
  - `edge_valid` in the same cycle the idle counter would reach TIMEOUT: the edge wins and the counter clears.
  - Error and good sync cannot coincide, since an edge has exactly one class.
- Reset mid-operation: all state returns to reset values asynchronously. Outputs are valid at their reset values while `resetb` = 0.

## Timing
- All outputs registered.
- Classification and state update use the `edge_valid` cycle. Results are visible on the next `clk_in` edge.
- Thresholds, `dec_restart` (1 cycle), `dec_run` and `lock_state` = 2 all update in the cycle after the MEAS_EDGES-th edge.
- `audio_locked` rises 1 cycle after the `edge_valid` of the SYNC_NEEDED-th good sync. It falls 1 cycle after the error edge that reaches ERR_LIMIT, or after timeout.
- `sync_pulse` goes high 1 cycle after its long-edge `edge_valid`, for 1 cycle.
- `edge_valid` may arrive on consecutive cycles. No backpressure.

## Test plan
- Reset and defaults: hold `resetb` = 0, then release with no edges.
  - Required: thresholds 20/38/42, every other output 0, `lock_state` = 0.
- Acquisition at u = 14: 64 edges with lengths from {14, 28, 42}, then a clean subframe stream (each subframe 64 UI with B/M/W preambles).
  - Required: T1/T2/T3 = 21/35/39; one `dec_restart` pulse.
  - Required: `audio_locked` = 1 exactly 1 cycle after the 4th good sync.
- Low-UI rejection: 64 edges with minimum length 3.
  - Required: remains in MEASURE (`lock_state` = 1) with thresholds unchanged.
- Error scoring: after lock, inject length 37 (invalid) on 4 edges with no good sync between.
  - Required: `err` reaches 8 and `audio_locked` drops 1 cycle after the 4th.
  - Variant: separate the invalid edges with good syncs. Required: lock is retained.
- Loss of signal: after lock, stop edges for 1023 cycles.
  - Required: IDLE, `dec_run` = 0, thresholds 21/35/39 retained.
  - Variant: an edge landing on cycle 1023. Required: no timeout.
- Bad sync spacing: during CONFIRM, place a long edge at `acc_new` = 60.
  - Required: return to MEASURE, `dec_run` = 0.
  - Required: asserting `resetb` mid-CONFIRM clears all outputs immediately, without waiting for a clock.
